vector_mem_unit: RTL

Vector load/store sequencer that acts as the initiator on the data port of the processor's shared memory (`topMemory`: address, write-enable, write-data in; read-data out). It turns one vector load or store request from the execute stage into LANES consecutive single-pixel memory accesses. Loads are packed into a vector register image; stores are unpacked from one. It sits between the vector execute stage and the memory data port, and leaves the instruction port untouched.

---
 rtl/vector_mem_pkg.sv | 19 +
 rtl/vmu_addr_gen.sv | 48 ++++
 rtl/vector_mem_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vector_mem_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vector_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        STORE = 2'd3
    } vmu_state_t;

    localparam logic VMU_OP_LOAD  = 1'b0;
    localparam logic VMU_OP_STORE = 1'b1;

    // Lane counter width; a single-lane unit still needs one counter bit.
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vmu_addr_gen.sv
// Lane counter plus base+lane address adder (wraps modulo 2^WIDTH).
module vmu_addr_gen
    import vector_mem_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int LANES = 8,
    parameter int LW    = lane_bits(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             step,
    input  logic [WIDTH-1:0] base_in,
    output logic [LW-1:0]    lane,
    output logic [LW-1:0]    lane_nxt,
    output logic             last,
    output logic [WIDTH-1:0] addr_nxt
);

    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] base_nxt;

    // Look-ahead values so the owner can register the address of the next beat.
    always_comb begin
        lane_nxt = lane;
        base_nxt = base_q;
        if (init) begin
            lane_nxt = '0;
            base_nxt = base_in;
        end else if (step) begin
            lane_nxt = lane + LW'(1);
        end
    end

    assign addr_nxt = base_nxt + WIDTH'(lane_nxt);
    assign last     = (lane == LW'(LANES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane   <= '0;
            base_q <= '0;
        end else begin
            lane   <= lane_nxt;
            base_q <= base_nxt;
        end
    end

endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer: one request becomes LANES single-pixel memory beats.
module vector_mem_unit
    import vector_mem_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int PIXEL = 8,
    parameter int LANES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_store,
    input  logic [WIDTH-1:0]       base_addr,
    input  logic [LANES*PIXEL-1:0] store_data,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*PIXEL-1:0] load_data,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_wd,
    input  logic [WIDTH-1:0]       mem_rd,
    output logic [1:0]             dbg_state
);

    localparam int LW = lane_bits(LANES);

    // Handshake: start is a strobe honoured only in IDLE; done is a one-cycle
    // pulse and there is no backpressure on the memory port.
    vmu_state_t state, state_nxt;

    logic                   init, step, issue, cap, fin, last;
    logic [LW-1:0]          lane, lane_nxt, cap_idx;
    logic [WIDTH-1:0]       addr_nxt;
    logic [LANES*PIXEL-1:0] sd_q, sd_src;
    logic [PIXEL-1:0]       wd_elem;
    logic                   unused_rd_hi;

    vmu_addr_gen #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .LW    (LW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .step     (step),
        .base_in  (base_addr),
        .lane     (lane),
        .lane_nxt (lane_nxt),
        .last     (last),
        .addr_nxt (addr_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        init      = 1'b0;
        step      = 1'b0;
        issue     = 1'b0;
        cap       = 1'b0;
        fin       = 1'b0;
        cap_idx   = lane - LW'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    init      = 1'b1;
                    issue     = 1'b1;
                    state_nxt = (op_store == VMU_OP_STORE) ? STORE : LOAD;
                end
            end
            STORE: begin
                if (last) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    step  = 1'b1;
                    issue = 1'b1;
                end
            end
            LOAD: begin
                // Read data trails its address by one cycle, so lane k-1 lands now.
                cap = (lane != '0);
                if (last) begin
                    state_nxt = DRAIN;
                end else begin
                    step  = 1'b1;
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                cap       = 1'b1;
                cap_idx   = LW'(LANES - 1);
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // On the accepting edge the operand comes straight from the port.
    assign sd_src       = init ? store_data : sd_q;
    assign wd_elem      = sd_src[int'(lane_nxt)*PIXEL +: PIXEL];
    assign unused_rd_hi = ^mem_rd[WIDTH-1:PIXEL];
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            load_data <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            sd_q      <= '0;
        end else begin
            done   <= fin;
            mem_we <= issue && (state_nxt == STORE);
            if (init) begin
                busy <= 1'b1;
                sd_q <= store_data;
            end else if (fin) begin
                busy <= 1'b0;
            end
            if (issue) mem_addr <= addr_nxt;
            if (issue && (state_nxt == STORE)) mem_wd <= WIDTH'(wd_elem);
            if (cap) load_data[int'(cap_idx)*PIXEL +: PIXEL] <= mem_rd[PIXEL-1:0];
        end
    end

endmodule
